// File: rtl/mdp3_stream_ingress.sv
// Store-and-forward ingress buffer for MDP3 Avalon-ST packets: only whole, well-framed
// packets that fit are committed and forwarded; the rest are dropped and counted.
module mdp3_stream_ingress #(
    parameter int DATA_W        = 64,
    parameter int EMPTY_W       = 3,
    parameter int DEPTH         = 256,
    parameter int MAX_PKT_WORDS = 64,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid,
    input  logic                     start_packet,
    input  logic                     end_packet,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [EMPTY_W-1:0]       empty,
    output logic                     ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [EMPTY_W-1:0]       out_empty,
    output logic [$clog2(DEPTH):0]   used_words,
    output logic [CNT_W-1:0]         pkt_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic [CNT_W-1:0]         err_count
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [ADDR_W:0] ptr_t;
    localparam ptr_t DEPTH_V = ptr_t'(DEPTH);
    localparam ptr_t MAX_V   = ptr_t'(MAX_PKT_WORDS);
    localparam ptr_t ONE     = ptr_t'(1);

    typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_t;

    typedef struct packed {
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [DATA_W-1:0]  data;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    entry_t    mem [DEPTH];
    wr_state_t state;
    ptr_t      wr_ptr, wr_commit, rd_ptr, fetch_ptr, beat_cnt;

    // rd_ptr only advances on a downstream handshake, so entries held in the
    // skid/output registers still occupy buffer space until they leave.
    logic sop_beat, cont_beat, room_sop, room_cont, wr_en;
    ptr_t wr_addr, wr_next;

    assign sop_beat  = valid & start_packet;
    assign cont_beat = valid & ~start_packet;
    assign room_sop  = (wr_commit - rd_ptr) < DEPTH_V;
    assign room_cont = ((wr_ptr - rd_ptr) < DEPTH_V) && (beat_cnt < MAX_V);
    assign wr_addr   = start_packet ? wr_commit : wr_ptr;
    assign wr_next   = wr_addr + ONE;
    assign wr_en     = (sop_beat & room_sop) | (cont_beat & (state == RECV) & room_cont);

    // NOTE: the storage array has no reset; only pointers define what is valid, and
    // leaving it unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[ADDR_W-1:0]] <= {end_packet, empty, data_in};
        end
    end

    // NOTE: every register in a clocked block uses <=, so all of them sample the
    // pre-edge values of one another regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            beat_cnt   <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            err_count  <= '0;
            ready      <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (sop_beat) begin
                // SOP always restarts from the committed boundary, discarding any partial.
                if (state == RECV) err_count <= sat_inc(err_count);
                if (!room_sop) begin
                    wr_ptr     <= wr_commit;
                    drop_count <= sat_inc(drop_count);
                    state      <= end_packet ? IDLE : DROP;
                end else if (end_packet) begin
                    wr_ptr    <= wr_next;
                    wr_commit <= wr_next;
                    pkt_count <= sat_inc(pkt_count);
                    state     <= IDLE;
                end else begin
                    wr_ptr   <= wr_next;
                    beat_cnt <= ONE;
                    state    <= RECV;
                end
            end else if (cont_beat) begin
                case (state)
                    IDLE: err_count <= sat_inc(err_count);
                    RECV: begin
                        if (room_cont) begin
                            wr_ptr   <= wr_next;
                            beat_cnt <= beat_cnt + ONE;
                            if (end_packet) begin
                                wr_commit <= wr_next;
                                pkt_count <= sat_inc(pkt_count);
                                state     <= IDLE;
                            end
                        end else begin
                            wr_ptr     <= wr_commit;
                            drop_count <= sat_inc(drop_count);
                            state      <= end_packet ? IDLE : DROP;
                        end
                    end
                    DROP:    if (end_packet) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Read side: fetch_ptr feeds a one-entry skid register, which feeds the output stage.
    entry_t rd_entry, skid_entry;
    logic   skid_valid, skid_sop, next_sop, out_load, fetch;

    assign rd_entry = mem[fetch_ptr[ADDR_W-1:0]];
    assign out_load = skid_valid & (~out_valid | out_ready);
    assign fetch    = (fetch_ptr != wr_commit) & (~skid_valid | out_load);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_ptr  <= '0;
            rd_ptr     <= '0;
            skid_valid <= 1'b0;
            skid_entry <= '0;
            skid_sop   <= 1'b0;
            next_sop   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_empty  <= '0;
        end else begin
            if (fetch) begin
                skid_entry <= rd_entry;
                skid_sop   <= next_sop;
                next_sop   <= rd_entry.eop;
                fetch_ptr  <= fetch_ptr + ONE;
                skid_valid <= 1'b1;
            end else if (out_load) begin
                skid_valid <= 1'b0;
            end

            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= skid_entry.data;
                out_sop   <= skid_sop;
                out_eop   <= skid_entry.eop;
                out_empty <= skid_entry.empty;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready) rd_ptr <= rd_ptr + ONE;
        end
    end

    assign used_words = wr_commit - rd_ptr;

endmodule

// File: tb/tb_mdp3_stream_ingress.sv
// Scoreboard bench for mdp3_stream_ingress: a packet-level reference model predicts
// committed beats and counters; a negedge monitor checks every output handshake.
module tb_mdp3_stream_ingress;
    localparam int DATA_W = 64;
    localparam int EMPTY_W = 3;
    localparam int DEPTH = 8;
    localparam int MAX_PKT = 6;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               valid = 1'b0;
    logic               start_packet = 1'b0;
    logic               end_packet = 1'b0;
    logic [DATA_W-1:0]  data_in = '0;
    logic [EMPTY_W-1:0] empty = '0;
    logic               ready;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [DATA_W-1:0]  out_data;
    logic               out_sop, out_eop;
    logic [EMPTY_W-1:0] out_empty;
    logic [3:0]         used_words;
    logic [CNT_W-1:0]   pkt_count, drop_count, err_count;

    mdp3_stream_ingress #(
        .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH),
        .MAX_PKT_WORDS(MAX_PKT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .start_packet(start_packet),
        .end_packet(end_packet), .data_in(data_in), .empty(empty), .ready(ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .used_words(used_words), .pkt_count(pkt_count), .drop_count(drop_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;
    typedef enum {M_IDLE, M_RECV, M_DROP} mmode_t;

    beat_t  exp_q[$];
    beat_t  part_q[$];
    mmode_t m_mode = M_IDLE;
    int     m_pkt = 0, m_drop = 0, m_err = 0;
    int     committed = 0, retired = 0;

    task automatic model_clear();
        exp_q.delete();
        part_q.delete();
        m_mode = M_IDLE;
        m_pkt = 0; m_drop = 0; m_err = 0;
        committed = 0; retired = 0;
    endtask

    task automatic commit_partial();
        int n = part_q.size();
        for (int i = 0; i < n; i++) begin
            beat_t b = part_q[i];
            b.sop = (i == 0);
            exp_q.push_back(b);
        end
        committed += n;
        m_pkt++;
        part_q.delete();
    endtask

    // Called when a beat is driven; retired then counts handshakes up to the previous edge.
    task automatic model_beat(input logic sop, input logic eop, input logic [63:0] d,
                              input logic [2:0] e);
        beat_t b;
        b.data = d; b.sop = 1'b0; b.eop = eop; b.empty = e;
        if (sop) begin
            if (m_mode == M_RECV) m_err++;
            part_q.delete();
            if (committed - retired < DEPTH) begin
                part_q.push_back(b);
                if (eop) begin commit_partial(); m_mode = M_IDLE; end
                else m_mode = M_RECV;
            end else begin
                m_drop++;
                m_mode = eop ? M_IDLE : M_DROP;
            end
        end else begin
            case (m_mode)
                M_IDLE: m_err++;
                M_RECV: begin
                    if (committed + part_q.size() - retired < DEPTH && part_q.size() < MAX_PKT) begin
                        part_q.push_back(b);
                        if (eop) begin commit_partial(); m_mode = M_IDLE; end
                    end else begin
                        m_drop++;
                        part_q.delete();
                        m_mode = eop ? M_IDLE : M_DROP;
                    end
                end
                default: if (eop) m_mode = M_IDLE;
            endcase
        end
    endtask

    // ---------------- monitor ----------------
    beat_t       mon_b;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [4:0]  prev_frame;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, prev_data);
                check("stall_frame", 64'({out_sop, out_eop, out_empty}), 64'(prev_frame));
            end
            if (out_valid && out_ready) begin
                retired++;
                check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    mon_b = exp_q.pop_front();
                    check("out_data", out_data, mon_b.data);
                    check("out_sop", 64'(out_sop), 64'(mon_b.sop));
                    check("out_eop", 64'(out_eop), 64'(mon_b.eop));
                    if (mon_b.eop) check("out_empty", 64'(out_empty), 64'(mon_b.empty));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_frame = {out_sop, out_eop, out_empty};
        end
    end

    // out_ready pattern: 0 hold high, 1 hold low, 2 toggle, 3 random
    int rmode = 0;
    always begin
        @(posedge clk);
        #2;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic send_beat(input logic sop, input logic eop, input logic [63:0] d,
                             input logic [2:0] e);
        model_beat(sop, eop, d, e);
        valid = 1'b1; start_packet = sop; end_packet = eop; data_in = d; empty = e;
        @(posedge clk); #1;
        valid = 1'b0; start_packet = 1'b0; end_packet = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [63:0] base, input bit close,
                            input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic [63:0] d = rnd ? {$urandom(), $urandom()} : base + 64'(i);
            send_beat(i == 0, close && (i == n - 1), d, 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin @(posedge clk); #1; n++; end
        idle(3);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_counters", 64'({pkt_count, drop_count, err_count}), 64'd0);
        check("rst_used", 64'(used_words), 64'd0);
        check("rst_out_regs", 64'({out_sop, out_eop, out_empty}) | out_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(ready), 64'd1);
    endtask

    initial begin
        #1;
        do_reset();

        // Single-beat packet latency
        rmode = 0;
        send_beat(1'b1, 1'b1, 64'h1111, 3'd5);
        check("lat_edge0", 64'(out_valid), 64'd0);
        idle(1);
        check("lat_edge1", 64'(out_valid), 64'd0);
        idle(1);
        check("lat_edge2", 64'(out_valid), 64'd1);
        check("lat_frame", 64'({out_sop, out_eop, out_empty}), 64'b11101);
        check("lat_pkt_count", 64'(pkt_count), 64'd1);
        drain("lat_drain", 20);

        // Back-to-back packets stream contiguously
        do_reset();
        fork
            begin
                send_pkt(4, 64'hA0, 1'b1, 1'b0);
                send_pkt(3, 64'hB0, 1'b1, 1'b0);
            end
            begin
                int n = 0;
                while (!out_valid && n < 30) begin @(negedge clk); n++; end
                check("tp_start", 64'(out_valid), 64'd1);
                repeat (6) begin
                    @(negedge clk);
                    check("tp_contiguous", 64'(out_valid), 64'd1);
                end
            end
        join
        drain("tp_drain", 30);
        check("tp_pkt_count", 64'(pkt_count), 64'd2);

        // Overflow with stalled output
        do_reset();
        rmode = 1;
        idle(1);
        send_pkt(6, 64'h60, 1'b1, 1'b0);
        send_pkt(4, 64'h70, 1'b1, 1'b0);
        idle(1);
        check("ovf_drop", 64'(drop_count), 64'd1);
        check("ovf_used", 64'(used_words), 64'd6);
        rmode = 0;
        drain("ovf_drain", 40);
        check("ovf_pkt_count", 64'(pkt_count), 64'd1);

        // Oversize packet
        do_reset();
        send_pkt(7, 64'h170, 1'b1, 1'b0);
        send_pkt(2, 64'h180, 1'b1, 1'b0);
        drain("big_drain", 30);
        check("big_drop", 64'(drop_count), 64'd1);
        check("big_pkt", 64'(pkt_count), 64'd1);

        // Framing errors
        do_reset();
        send_beat(1'b0, 1'b0, 64'h99, 3'd0);
        idle(1);
        check("frm_err1", 64'(err_count), 64'd1);
        send_beat(1'b1, 1'b0, 64'hC0, 3'd0);
        send_beat(1'b0, 1'b0, 64'hC1, 3'd0);
        send_beat(1'b1, 1'b1, 64'hD0, 3'd2);
        drain("frm_drain", 30);
        check("frm_err2", 64'(err_count), 64'd2);
        check("frm_pkt", 64'(pkt_count), 64'd1);

        // Reset mid-packet discards everything
        rmode = 1;
        idle(1);
        send_pkt(3, 64'hE0, 1'b1, 1'b0);
        send_beat(1'b1, 1'b0, 64'hF0, 3'd0);
        send_beat(1'b0, 1'b0, 64'hF1, 3'd0);
        do_reset();
        rmode = 0;
        send_pkt(2, 64'h550, 1'b1, 1'b0);
        drain("mid_rst_drain", 30);
        check("mid_rst_pkt", 64'(pkt_count), 64'd1);

        // Backpressure toggling, pointer wrap
        do_reset();
        rmode = 2;
        for (int k = 0; k < 20; k++) begin
            send_pkt(3, 64'h1000 + 64'(k * 16), 1'b1, 1'b0);
            idle(4);
        end
        drain("wrap_drain", 100);
        check("wrap_pkt", 64'(pkt_count), 64'd20);
        check("wrap_drop", 64'(drop_count), 64'd0);
        check("wrap_err", 64'(err_count), 64'd0);

        // Randomized traffic against the model
        do_reset();
        rmode = 3;
        for (int k = 0; k < 250; k++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 0)
                send_beat(1'b0, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 3'd0);
            else if (kind == 1)
                send_pkt($urandom_range(1, 4), 64'd0, 1'b0, 1'b1);
            else
                send_pkt($urandom_range(1, 8), 64'd0, 1'b1, 1'b1);
            idle($urandom_range(0, 3));
        end
        send_pkt(2, 64'd0, 1'b1, 1'b1);
        rmode = 0;
        drain("rand_drain", 200);
        check("rand_pkt", 64'(pkt_count), 64'(m_pkt));
        check("rand_drop", 64'(drop_count), 64'(m_drop));
        check("rand_err", 64'(err_count), 64'(m_err));
        check("rand_used", 64'(used_words), 64'(committed - retired));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdp3_stream_ingress.md
# mdp3_stream_ingress

Parametrised store-and-forward ingress buffer for MDP3 Avalon-ST packets. It sits between the MAC-side stream and the message parser, replacing the fixed packetizer/64x256 FIFO pairing. Only whole, well-framed packets that fit in the buffer reach the parser; overflowing, oversize or malformed packets are dropped and counted. The input is never back-pressured.

## Interface

- DATA_W, 64: beat width in bits; must be a multiple of 8.
- EMPTY_W, 3: width of `empty`, equal to log2(DATA_W/8).
- DEPTH, 256: buffer entries; must be a power of two ≥ 4; ADDR_W = log2(DEPTH).
- MAX_PKT_WORDS, 64: largest accepted packet in beats; must be ≤ DEPTH.
- CNT_W, 16: width of the statistics counters.

Ports:

- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid  in  1  input beat valid.
- start_packet  in  1  SOP of the beat.
- end_packet  in  1  EOP of the beat.
- data_in  in  DATA_W  beat data.
- empty  in  EMPTY_W  unused bytes in the EOP beat.
- ready  out  1  input ready; 0 in reset, 1 from the first edge after reset release.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  output data.
- out_sop, out_eop  out  1 each  output framing.
- out_empty  out  EMPTY_W  output empty; meaningful only when out_eop = 1.
- used_words  out  ADDR_W+1  committed words not yet read from the buffer.
- pkt_count, drop_count, err_count  out  CNT_W each  saturating statistics.

## Operation

- Each entry stores {eop, empty, data}. SOP is implied: it is the first entry after an EOP, or the first entry after reset.
- Pointers are ADDR_W+1 bits wide and wrap naturally. The pointers are:
  - `wr_ptr`: speculative write pointer.
  - `wr_commit`: end of committed data.
  - `rd_ptr`: read pointer.
- Space exists when wr_ptr − rd_ptr < DEPTH.
- Write FSM states are IDLE, RECV and DROP. Only beats with valid = 1 count.
  - IDLE + SOP: write the beat, set beat count to 1, go to RECV. If EOP is also set, commit immediately, increment pkt_count and stay in IDLE.
  - IDLE, no SOP: discard the beat and increment err_count.
  - RECV, no SOP, with space and beat count < MAX_PKT_WORDS: write the beat. If EOP, set wr_commit to the post-write pointer, increment pkt_count and go to IDLE.
  - RECV, no space or beat count = MAX_PKT_WORDS: set wr_ptr back to wr_commit and increment drop_count. If this beat has EOP, go to IDLE; otherwise go to DROP.
  - RECV + SOP: the partial packet is rolled back and err_count is incremented. The beat is then treated as IDLE + SOP in the same cycle.
  - DROP: discard beats until EOP, then go to IDLE. SOP in DROP is handled as IDLE + SOP.
- The read side sees only committed data (rd_ptr ≠ wr_commit). It uses a one-entry registered output stage plus a one-entry prefetch/skid register, so with out_ready held high it sustains 1 beat/cycle.
- out_* is held stable while out_valid = 1 and out_ready = 0.
- used_words = wr_commit − rd_ptr.
- All counters saturate at 2^CNT_W − 1.

## Timing

- Reset (asynchronous assert, synchronous release): every pointer is 0, FSM is IDLE, and out_valid, out_sop, out_eop, out_empty, out_data, used_words and all counters are 0. ready is 0.
- Assertion of reset_n mid-packet discards all buffered and partial data. No counter increments for the lost data.
- Commit latency: the EOP beat is sampled at edge T, and wr_commit is visible after T. With an empty output path, the packet's first beat has out_valid = 1 after edge T+2.
- pkt_count, drop_count and err_count update on the same edge that samples the causing beat.
- Simultaneous commit and read: used_words reflects both at the same edge.
- Full boundary: a beat needing the DEPTH-th free slot is accepted when exactly one slot remains. It is dropped when none remain.
- Reads freeing space in the same cycle do not count until the next cycle.

## Test plan

Run with DEPTH = 8, MAX_PKT_WORDS = 6 and out_ready = 1 unless stated.

- Reset: out_valid = 0, counters 0, ready = 0 in reset. Single-beat packet (SOP+EOP, data 0x1111, empty 5) → out_valid after 2 edges with sop = eop = 1 and out_empty = 5; pkt_count = 1.
- Throughput: a 4-beat packet 0xA0..0xA3 followed by a 3-beat packet 0xB0..0xB2 with no gaps → 7 contiguous output beats in order. SOP appears on 0xA0 and 0xB0; pkt_count = 2.
- Overflow: out_ready = 0, then send a 6-beat packet and a 4-beat packet. The second is dropped at its 3rd beat: drop_count = 1, used_words = 6. Releasing out_ready yields only the 6 beats.
- Oversize: a 7-beat packet → drop_count = 1, no output. The next 2-beat packet passes intact.
- Framing: a beat with no SOP in IDLE → err_count = 1. SOP 0xC0, 0xC1, then SOP 0xD0 + EOP → err_count = 2 and only 0xD0 is output.
- Backpressure/wrap: toggle out_ready every cycle across 20 packets of 3 beats. The output must be loss-free and in order, the pointers wrap, and out_* stays stable while stalled.
